// File: rtl/rtype_issue_if.sv
`default_nettype none
// ============================================================================
//  Module      : rtype_issue_if
//  Description : Instruction handshake, register preload, ALU operand/result
//                and retire signals bundled between the issue unit and its
//                neighbours (fetch/decode host, ALU).
//  Revision    : 1.0 - initial release
// ============================================================================
interface rtype_issue_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [31:0] load_data;
    logic        alu_enable;
    logic [2:0]  alu_funct3;
    logic [31:0] alu_rs1_value;
    logic [31:0] alu_rs2_value;
    logic [31:0] alu_rd_value;
    logic        retire_valid;
    logic [4:0]  retire_rd;
    logic [31:0] retire_value;
    logic        illegal;

    // Host / ALU side: offers instructions, preloads registers, returns ALU results.
    modport master (
        output instr_valid, instr, load_en, load_addr, load_data, alu_rd_value,
        input  instr_ready, alu_enable, alu_funct3, alu_rs1_value, alu_rs2_value,
        input  retire_valid, retire_rd, retire_value, illegal
    );

    // Issue unit side.
    modport slave (
        input  instr_valid, instr, load_en, load_addr, load_data, alu_rd_value,
        output instr_ready, alu_enable, alu_funct3, alu_rs1_value, alu_rs2_value,
        output retire_valid, retire_rd, retire_value, illegal
    );
endinterface
`default_nettype wire

// File: rtl/rtype_issue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rtype_issue_unit
//  Description : Accepts RV32I R-type instructions one at a time, reads the
//                32x32 register file, drives the ALU for one cycle, captures
//                its registered result and writes it back to rd.
//                Optional macro RV_ALT_OPS_EN: SUB and SRA (funct7=0100000)
//                are legal and computed locally instead of by the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtype_issue_unit #(
    parameter int          REG_COUNT   = 32,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  wire logic   clock,
    input  wire logic   reset_n,
    rtype_issue_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_TRAP    = 2'd3
    } state_t;

    localparam logic [6:0] C_OPCODE_OP   = 7'b0110011;
    localparam logic [6:0] C_FUNCT7_BASE = 7'b0000000;
`ifdef RV_ALT_OPS_EN
    localparam logic [6:0] C_FUNCT7_ALT  = 7'b0100000;
`endif

    state_t      r_state;
    state_t      w_next_state;
    logic [4:0]  r_rd;
    logic [31:0] r_regs [REG_COUNT];
    logic        r_alu_enable;
    logic [2:0]  r_alu_funct3;
    logic [31:0] r_alu_rs1_value;
    logic [31:0] r_alu_rs2_value;

    // Decode of the instruction currently offered on the bus.
    logic [6:0]  w_opcode;
    logic [6:0]  w_funct7;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_rs1_value;
    logic [31:0] w_rs2_value;
    logic        w_is_alt;
    logic        w_legal;
    logic        w_accept;
    logic        w_is_shift;
    logic [31:0] w_capture_value;

    assign w_opcode = bus.instr[6:0];
    assign w_rd     = bus.instr[11:7];
    assign w_funct3 = bus.instr[14:12];
    assign w_rs1    = bus.instr[19:15];
    assign w_rs2    = bus.instr[24:20];
    assign w_funct7 = bus.instr[31:25];

    // x0 is never stored; its reads are forced to zero here.
    assign w_rs1_value = (w_rs1 == 5'd0) ? 32'h0 : r_regs[w_rs1];
    assign w_rs2_value = (w_rs2 == 5'd0) ? 32'h0 : r_regs[w_rs2];

    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

`ifdef RV_ALT_OPS_EN
    logic        r_alt_op;
    logic [31:0] r_alt_result;
    logic [31:0] w_alt_result;

    assign w_is_alt = (w_funct7 == C_FUNCT7_ALT) &&
                      ((w_funct3 == 3'b000) || (w_funct3 == 3'b101));
    assign w_alt_result = (w_funct3 == 3'b000) ?
                          (w_rs1_value - w_rs2_value) :
                          32'($signed(w_rs1_value) >>> w_rs2_value[4:0]);
    assign w_capture_value = r_alt_op ? r_alt_result : bus.alu_rd_value;

    // Local SUB/SRA result is computed from the operands read at accept time.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_alt_op     <= 1'b0;
            r_alt_result <= 32'h0;
        end else if (w_accept) begin
            r_alt_op     <= w_is_alt;
            r_alt_result <= w_alt_result;
        end
    end
`else
    assign w_is_alt        = 1'b0;
    assign w_capture_value = bus.alu_rd_value;
`endif

    assign w_legal  = (w_opcode == C_OPCODE_OP) &&
                      ((w_funct7 == C_FUNCT7_BASE) || w_is_alt);
    assign bus.instr_ready = reset_n && (r_state == S_IDLE);
    assign w_accept = bus.instr_valid && bus.instr_ready;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and the per-state pulse outputs (retire, illegal).
    always_comb begin
        w_next_state     = r_state;
        bus.retire_valid = 1'b0;
        bus.retire_rd    = 5'd0;
        bus.retire_value = 32'h0;
        bus.illegal      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_legal ? S_ISSUE : S_TRAP;
                end
            end
            S_ISSUE: begin
                w_next_state = S_CAPTURE;
            end
            S_CAPTURE: begin
                bus.retire_valid = 1'b1;
                bus.retire_rd    = r_rd;
                bus.retire_value = w_capture_value;
                w_next_state     = S_IDLE;
            end
            S_TRAP: begin
                bus.illegal  = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Destination index held from accept until writeback.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rd <= 5'd0;
        end else if (w_accept) begin
            r_rd <= w_rd;
        end
    end

    // ALU outputs are loaded at accept so they are valid through ISSUE, then held.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_alu_enable    <= 1'b0;
            r_alu_funct3    <= 3'd0;
            r_alu_rs1_value <= 32'h0;
            r_alu_rs2_value <= 32'h0;
        end else begin
            r_alu_enable <= 1'b0;
            if (w_accept && w_legal && !w_is_alt) begin
                r_alu_enable    <= 1'b1;
                r_alu_funct3    <= w_funct3;
                r_alu_rs1_value <= w_rs1_value;
                r_alu_rs2_value <= w_is_shift ? {27'b0, w_rs2_value[4:0]} : w_rs2_value;
            end
        end
    end

    assign bus.alu_enable    = r_alu_enable;
    assign bus.alu_funct3    = r_alu_funct3;
    assign bus.alu_rs1_value = r_alu_rs1_value;
    assign bus.alu_rs2_value = r_alu_rs2_value;

    // Register file: writeback in CAPTURE, host preload only in IDLE when no handshake fires.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= (i == 0) ? 32'h0 : RESET_VALUE;
            end
        end else if (r_state == S_CAPTURE) begin
            if (r_rd != 5'd0) begin
                r_regs[r_rd] <= w_capture_value;
            end
        end else if ((r_state == S_IDLE) && bus.load_en && !w_accept &&
                     (bus.load_addr != 5'd0)) begin
            r_regs[bus.load_addr] <= bus.load_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rtype_issue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtype_issue_unit
//  Description : Directed bench for rtype_issue_unit with a cycle-scheduled
//                reference model, a clocked ALU responder and a per-cycle
//                compare process. Honours RV_ALT_OPS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rtype_issue_unit;

    localparam logic [31:0] RESET_VALUE = 32'h0;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    rtype_issue_if bus ();

    rtype_issue_unit #(.REG_COUNT(32), .RESET_VALUE(RESET_VALUE)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    // Reference RV32I register-register arithmetic.
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        case (f3)
            3'd0:    return a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {31'b0, $signed(a) < $signed(b)};
            3'd3:    return {31'b0, a < b};
            3'd4:    return a ^ b;
            3'd5:    return a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    // Registered ALU: result appears the cycle after enable; garbage otherwise.
    always @(posedge clock) begin
        if (bus.alu_enable)
            bus.alu_rd_value <= ref_alu(bus.alu_funct3, bus.alu_rs1_value, bus.alu_rs2_value);
        else
            bus.alu_rd_value <= 32'hDEADBEEF;
    end

    // ---------------- reference model (edge-scheduled events) ----------------
    logic [31:0] m_x [32];
    int          e       = 0;
    int          free_at = 0;
    int          ret_at  = -1;
    int          wb_at   = -1;
    logic [4:0]  p_rd    = 5'd0;
    logic [31:0] p_val   = 32'h0;
    logic        m_en = 1'b0, m_ret = 1'b0, m_ill = 1'b0, m_after_rst = 1'b0;
    logic [2:0]  m_f3 = 3'd0;
    logic [31:0] m_a = 32'h0, m_b = 32'h0;

    always @(posedge clock) begin
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic        alt, legal;
        e++;
        m_en  = 1'b0;
        m_ret = 1'b0;
        m_ill = 1'b0;
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) m_x[i] = (i == 0) ? 32'h0 : RESET_VALUE;
            m_f3 = 3'd0; m_a = 32'h0; m_b = 32'h0;
            free_at = 0; ret_at = -1; wb_at = -1;
            m_after_rst = 1'b1;
        end else begin
            m_after_rst = 1'b0;
            if (e == wb_at && p_rd != 5'd0) m_x[p_rd] = p_val;
            if (e == ret_at) m_ret = 1'b1;
            if (e >= free_at) begin
                if (bus.instr_valid) begin
                    op = bus.instr[6:0];
                    f7 = bus.instr[31:25];
                    f3 = bus.instr[14:12];
`ifdef RV_ALT_OPS_EN
                    alt = (f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5);
`else
                    alt = 1'b0;
`endif
                    legal = (op == 7'h33) && (f7 == 7'h00 || alt);
                    if (legal) begin
                        a = m_x[bus.instr[19:15]];
                        b = m_x[bus.instr[24:20]];
                        p_rd = bus.instr[11:7];
                        if (alt) begin
                            p_val = (f3 == 3'd0) ? a - b : 32'($signed(a) >>> b[4:0]);
                        end else begin
                            m_en  = 1'b1;
                            m_f3  = f3;
                            m_a   = a;
                            m_b   = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, b[4:0]} : b;
                            p_val = ref_alu(f3, a, b);
                        end
                        ret_at  = e + 1;
                        wb_at   = e + 2;
                        free_at = e + 3;
                    end else begin
                        m_ill   = 1'b1;
                        free_at = e + 2;
                    end
                end else if (bus.load_en && bus.load_addr != 5'd0) begin
                    m_x[bus.load_addr] = bus.load_data;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            check("m_ready", 32'(bus.instr_ready), 32'(reset_n && (e + 1 >= free_at)));
            check("m_alu_en", 32'(bus.alu_enable), 32'(m_en));
            check("m_alu_f3", 32'(bus.alu_funct3), 32'(m_f3));
            check("m_alu_rs1", bus.alu_rs1_value, m_a);
            check("m_alu_rs2", bus.alu_rs2_value, m_b);
            check("m_retire", 32'(bus.retire_valid), 32'(m_ret));
            check("m_illegal", 32'(bus.illegal), 32'(m_ill));
            if (m_ret) begin
                check("m_ret_rd", 32'(bus.retire_rd), 32'(p_rd));
                check("m_ret_val", bus.retire_value, p_val);
            end else if (m_after_rst) begin
                check("m_rst_rd", 32'(bus.retire_rd), 32'h0);
                check("m_rst_val", bus.retire_value, 32'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready();
        int n = 0;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!bus.instr_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 expected 1 at %0t", $time);
        end
    endtask

    task automatic preload(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clock);
        wait_ready();
        bus.load_en   = 1'b1;
        bus.load_addr = addr;
        bus.load_data = data;
        @(posedge clock);
        #2;
        bus.load_en = 1'b0;
    endtask

    // Returns 2 time units after the accept edge (inside the ISSUE/TRAP cycle).
    task automatic send(input logic [31:0] w);
        @(negedge clock);
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        wait_ready();
        @(posedge clock);
        #2;
        bus.instr_valid = 1'b0;
    endtask

    // Literal check of one ALU instruction: operands in ISSUE, retire in CAPTURE.
    task automatic run_lit(input string name, input logic [31:0] w, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res);
        send(w);
        check({name, "_en"}, 32'(bus.alu_enable), 32'h1);
        check({name, "_rs1"}, bus.alu_rs1_value, a);
        check({name, "_rs2"}, bus.alu_rs2_value, b);
        @(posedge clock);
        #2;
        check({name, "_en_off"}, 32'(bus.alu_enable), 32'h0);
        check({name, "_ret"}, 32'(bus.retire_valid), 32'h1);
        check({name, "_rd"}, 32'(bus.retire_rd), 32'(rd));
        check({name, "_val"}, bus.retire_value, res);
    endtask

    task automatic run_trap(input string name, input logic [31:0] w);
        send(w);
        check({name, "_ill"}, 32'(bus.illegal), 32'h1);
        check({name, "_en"}, 32'(bus.alu_enable), 32'h0);
        @(posedge clock);
        #2;
        check({name, "_ill_off"}, 32'(bus.illegal), 32'h0);
        check({name, "_noret"}, 32'(bus.retire_valid), 32'h0);
        check({name, "_ready"}, 32'(bus.instr_ready), 32'h1);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    initial begin
        vec_t vecs[4];
        bus.instr_valid = 1'b0;
        bus.instr       = 32'h0;
        bus.load_en     = 1'b0;
        bus.load_addr   = 5'd0;
        bus.load_data   = 32'h0;
        repeat (3) @(negedge clock);
        check("rst_ready", 32'(bus.instr_ready), 32'h0);
        check("rst_alu_en", 32'(bus.alu_enable), 32'h0);
        reset_n = 1'b1;

        // ADD x3,x1,x2
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        run_lit("add", 32'h002081B3, 32'd5, 32'd7, 5'd3, 32'd12);
        // read x3 back through an ADD x8,x3,x0
        run_lit("add_rb", rtype(7'h0, 5'd0, 5'd3, 3'd0, 5'd8), 32'd12, 32'd0, 5'd8, 32'd12);

        // SLL masks the shift amount
        preload(5'd1, 32'd1);
        preload(5'd2, 32'h00000024);
        run_lit("sll", rtype(7'h0, 5'd2, 5'd1, 3'd1, 5'd4), 32'd1, 32'd4, 5'd4, 32'd16);

        // SLT / SLTU with -1 and 1
        preload(5'd1, 32'hFFFFFFFF);
        preload(5'd2, 32'd1);
        run_lit("slt", rtype(7'h0, 5'd2, 5'd1, 3'd2, 5'd5), 32'hFFFFFFFF, 32'd1, 5'd5, 32'd1);
        run_lit("sltu", rtype(7'h0, 5'd2, 5'd1, 3'd3, 5'd10), 32'hFFFFFFFF, 32'd1, 5'd10, 32'd0);

        // logic ops and SRL
        preload(5'd1, 32'hF0F01234);
        preload(5'd2, 32'h00000F03);
        vecs[0] = '{3'd4, 5'd13, 32'h00000F03, 32'hF0F01D37};
        vecs[1] = '{3'd5, 5'd14, 32'h00000003, 32'h1E1E0246};
        vecs[2] = '{3'd6, 5'd15, 32'h00000F03, 32'hF0F01F37};
        vecs[3] = '{3'd7, 5'd16, 32'h00000F03, 32'h00000200};
        foreach (vecs[i])
            run_lit("logic", rtype(7'h0, 5'd2, 5'd1, vecs[i].f3, vecs[i].rd),
                    32'hF0F01234, vecs[i].b, vecs[i].rd, vecs[i].res);

        // rd == x0 still retires; x0 stays zero
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        run_lit("add_x0", rtype(7'h0, 5'd2, 5'd1, 3'd0, 5'd0), 32'd5, 32'd7, 5'd0, 32'd12);
        run_lit("x0_read", rtype(7'h0, 5'd0, 5'd0, 3'd0, 5'd6), 32'd0, 32'd0, 5'd6, 32'd0);

        // non R-type opcode, and funct7=0100000 with an unsupported funct3
        run_trap("addi", 32'h00000013);
        run_trap("alt_bad", rtype(7'h20, 5'd2, 5'd1, 3'd1, 5'd18));

        // handshake beats a same-cycle preload: x1 must keep 5
        bus.load_en   = 1'b1;
        bus.load_addr = 5'd1;
        bus.load_data = 32'd99;
        run_lit("hs_wins", rtype(7'h0, 5'd2, 5'd1, 3'd0, 5'd11), 32'd5, 32'd7, 5'd11, 32'd12);
        bus.load_en = 1'b0;
        run_lit("hs_rb", rtype(7'h0, 5'd0, 5'd1, 3'd0, 5'd12), 32'd5, 32'd0, 5'd12, 32'd5);

        // SUB / SRA
        preload(5'd1, 32'd3);
        preload(5'd2, 32'd5);
`ifdef RV_ALT_OPS_EN
        send(rtype(7'h20, 5'd2, 5'd1, 3'd0, 5'd7));
        check("sub_en", 32'(bus.alu_enable), 32'h0);
        @(posedge clock);
        #2;
        check("sub_ret", 32'(bus.retire_valid), 32'h1);
        check("sub_val", bus.retire_value, 32'hFFFFFFFE);
        preload(5'd1, 32'h80000000);
        preload(5'd2, 32'd4);
        send(rtype(7'h20, 5'd2, 5'd1, 3'd5, 5'd17));
        @(posedge clock);
        #2;
        check("sra_val", bus.retire_value, 32'hF8000000);
        run_lit("sub_rb", rtype(7'h0, 5'd0, 5'd7, 3'd0, 5'd19), 32'hFFFFFFFE, 32'd0, 5'd19, 32'hFFFFFFFE);
`else
        run_trap("sub", rtype(7'h20, 5'd2, 5'd1, 3'd0, 5'd7));
        run_trap("sra", rtype(7'h20, 5'd2, 5'd1, 3'd5, 5'd17));
`endif

        // reset during ISSUE aborts the instruction
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        send(32'h002081B3);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #2;
        check("rst_noret", 32'(bus.retire_valid), 32'h0);
        check("rst_en", 32'(bus.alu_enable), 32'h0);
        check("rst_rs1", bus.alu_rs1_value, 32'h0);
        check("rst_ready_low", 32'(bus.instr_ready), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        run_lit("rst_x3", rtype(7'h0, 5'd0, 5'd3, 3'd0, 5'd8), RESET_VALUE, 32'd0, 5'd8, RESET_VALUE);

        repeat (4) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete by %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
